// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the stage-count helper used to size the pipeline from WIDTH.
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic int stage_count(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter. It shifts by the constant 2^K when
// bit K of the carried shift amount is set, then registers the result together
// with its shamt, op, tag and valid bit. The stage can load whenever it is
// empty or the stage below will take its current contents.
// Optional rotate support is enabled by defining BSHIFT_ROTATE_EN.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int K     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      prev_valid,
    input  logic [WIDTH-1:0]          prev_data,
    input  logic [$clog2(WIDTH)-1:0]  prev_shamt,
    input  logic [1:0]                prev_op,
    input  logic [TAG_W-1:0]          prev_tag,
    input  logic                      next_ready,
    output logic                      valid,
    output logic [WIDTH-1:0]          data,
    output logic [$clog2(WIDTH)-1:0]  shamt,
    output logic [1:0]                op,
    output logic [TAG_W-1:0]          tag
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] shifted;
    logic             ready;

    assign ready = !valid || next_ready;

    // Shift the incoming operand by 2^K for the requested op, or pass it through.
    always_comb begin
        shifted = prev_data;
        if (prev_shamt[K]) begin
            case (prev_op)
                OP_SLL: shifted = prev_data << S;
                OP_SRL: shifted = prev_data >> S;
                OP_SRA: shifted = $unsigned($signed(prev_data) >>> S);
`ifdef BSHIFT_ROTATE_EN
                OP_ROR: shifted = {prev_data[S-1:0], prev_data[WIDTH-1:S]};
`else
                OP_ROR: shifted = prev_data >> S;
`endif
            endcase
        end
    end

    // Pipeline register: load when free or draining, hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            op    <= '0;
            tag   <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data  <= shifted;
                shamt <= prev_shamt;
                op    <= prev_op;
                tag   <= prev_tag;
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Parametrised pipelined barrel shifter: log2(WIDTH) shift_stage instances,
// each handling one bit of the shift amount, with a valid/ready handshake
// per stage. Define BSHIFT_ROTATE_EN to make op 11 a rotate right; otherwise
// op 11 behaves as a logical right shift.
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [$clog2(WIDTH)-1:0]  in_shamt,
    input  logic [1:0]                in_op,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_zero
);

    localparam int NSTAGE = stage_count(WIDTH);
    localparam int SHW    = $clog2(WIDTH);

    logic                 valid_p [0:NSTAGE];
    logic [WIDTH-1:0]     data_p  [0:NSTAGE];
    logic [SHW-1:0]       shamt_p [0:NSTAGE];
    logic [1:0]           op_p    [0:NSTAGE];
    logic [TAG_W-1:0]     tag_p   [0:NSTAGE];

    logic [NSTAGE-1:0]    valid_vec;
    logic [NSTAGE-1:0]    next_ready;
    logic                 unused_tail;

    assign valid_p[0] = in_valid;
    assign data_p[0]  = in_data;
    assign shamt_p[0] = in_shamt;
    assign op_p[0]    = in_op;
    assign tag_p[0]   = in_tag;

    // The readiness seen by stage k is "out_ready, or some later stage is
    // empty"; evaluating it from the valid flops directly is the unrolled
    // form of the per-stage ready chain and avoids a combinational self-loop.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        assign valid_vec[k] = valid_p[k+1];

        if (k == NSTAGE - 1) begin : g_last
            assign next_ready[k] = out_ready;
        end else begin : g_mid
            assign next_ready[k] = out_ready || !(&valid_vec[NSTAGE-1:k+1]);
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (valid_p[k]),
            .prev_data  (data_p[k]),
            .prev_shamt (shamt_p[k]),
            .prev_op    (op_p[k]),
            .prev_tag   (tag_p[k]),
            .next_ready (next_ready[k]),
            .valid      (valid_p[k+1]),
            .data       (data_p[k+1]),
            .shamt      (shamt_p[k+1]),
            .op         (op_p[k+1]),
            .tag        (tag_p[k+1])
        );
    end

    assign in_ready    = !valid_p[1] || next_ready[0];
    assign out_valid   = valid_p[NSTAGE];
    assign out_data    = data_p[NSTAGE];
    assign out_tag     = tag_p[NSTAGE];
    assign out_zero    = (data_p[NSTAGE] == '0);
    assign unused_tail = ^{shamt_p[NSTAGE], op_p[NSTAGE]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe at WIDTH = 32. A scoreboard of
// expected results is filled from a behavioural shift model whenever an
// operation is accepted, and every cycle with out_valid high is checked
// against the head entry. Honours BSHIFT_ROTATE_EN for the op 11 expectation.
module tb_barrel_shifter_pipe;

    localparam int W      = 32;
    localparam int TW     = 5;
    localparam int NSTAGE = 5;

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [4:0]    in_shamt;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          out_zero;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            cycle = 0;
    int            maxHeld = 0;
    int            popped = 0;
    int            lastLat = 0;
    logic [W-1:0]  lastOut = '0;
    logic          accepted = 1'b0;

    barrel_shifter_pipe #(
        .WIDTH (W),
        .TAG_W (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Reference shift built from wide arithmetic rather than staged muxing.
    function automatic logic [W-1:0] refShift(input logic [W-1:0] d, input logic [4:0] s,
                                              input logic [1:0] op);
        logic [2*W-1:0] wide;
        case (op)
            2'b00: return d << s;
            2'b01: return d >> s;
            2'b10: begin
                wide = {{W{d[W-1]}}, d} >> s;
                return wide[W-1:0];
            end
            default: begin
`ifdef BSHIFT_ROTATE_EN
                wide = {d, d} >> s;
                return wide[W-1:0];
`else
                return d >> s;
`endif
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Sample just after the falling edge, update the scoreboard, advance a cycle.
    task automatic step();
        int occ;
        exp_t e;
        #1;
        occ = sb.size();
        accepted = 1'b0;
        if (rst_n) begin
            checkOutput("in_ready", in_ready, (out_ready || occ < NSTAGE));
            if (out_valid) begin
                if (occ == 0) begin
                    checkOutput("spurious_valid", out_valid, 1'b0);
                end else begin
                    checkOutput("out_data", out_data, sb[0].data);
                    checkOutput("out_tag", out_tag, sb[0].tag);
                    checkOutput("out_zero", out_zero, (sb[0].data == '0));
                end
            end
            if (occ > maxHeld) maxHeld = occ;
            if (out_valid && out_ready && occ > 0) begin
                lastOut = out_data;
                lastLat = cycle - sb[0].acc;
                void'(sb.pop_front());
                popped++;
            end
            if (in_valid && in_ready) begin
                e.data = refShift(in_data, in_shamt, in_op);
                e.tag  = in_tag;
                e.acc  = cycle;
                sb.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [4:0] s,
                                 input logic [1:0] op, input logic [TW-1:0] t);
        in_valid = v;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_tag   = t;
        step();
    endtask

    task automatic waitDrain(input int budget);
        in_valid = 1'b0;
        for (int n = 0; n < budget && sb.size() > 0; n++) step();
        checkOutput("drain", sb.size(), 0);
    endtask

    task automatic runSingle(input string name, input logic [W-1:0] d, input logic [4:0] s,
                             input logic [1:0] op, input logic [W-1:0] want);
        out_ready = 1'b1;
        applyStimulus(1'b1, d, s, op, 5'd9);
        waitDrain(20);
        checkOutput({name, "_latency"}, lastLat, NSTAGE);
        checkOutput(name, lastOut, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nextTag;
        int issued;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        in_shamt  = 5'd3;
        in_op     = 2'b00;
        in_tag    = '0;
        out_ready = 1'b1;
        @(negedge clk);

        $display("[TB] reset with in_valid held high");
        applyStimulus(1'b1, 32'h1234_5678, 5'd3, 2'b00, 5'd1);
        applyStimulus(1'b1, 32'h1234_5678, 5'd3, 2'b00, 5'd1);
        checkOutput("reset_valid", out_valid, 1'b0);
        checkOutput("reset_data", out_data, '0);
        checkOutput("reset_tag", out_tag, '0);
        checkOutput("reset_zero", out_zero, 1'b1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            step();
            checkOutput("reset_idle", out_valid, 1'b0);
        end

        $display("[TB] directed shifts");
        runSingle("sll", 32'h8000_00F0, 5'd4, 2'b00, 32'h0000_0F00);
        runSingle("srl", 32'h8000_00F0, 5'd4, 2'b01, 32'h0800_000F);
        runSingle("sra", 32'h8000_00F0, 5'd4, 2'b10, 32'hF800_000F);
        runSingle("shamt0_sll", 32'hDEAD_BEEF, 5'd0, 2'b00, 32'hDEAD_BEEF);
        runSingle("shamt0_sra", 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF);
        runSingle("sra31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        runSingle("srl31", 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
        checkOutput("srl31_zero", out_zero, 1'b0);
`ifdef BSHIFT_ROTATE_EN
        runSingle("ror1", 32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000);
`else
        runSingle("ror1", 32'h0000_0001, 5'd1, 2'b11, 32'h0000_0000);
`endif

        $display("[TB] back-to-back with backpressure");
        maxHeld = 0;
        popped  = 0;
        nextTag = 0;
        for (int i = 0; i < 60 && (nextTag < 8 || sb.size() > 0); i++) begin
            out_ready = !(i >= 3 && i < 9);
            applyStimulus(nextTag < 8, $urandom, 5'($urandom_range(0, 31)),
                          2'($urandom_range(0, 3)), 5'(nextTag));
            if (accepted) nextTag++;
        end
        checkOutput("bp_issued", nextTag, 8);
        checkOutput("bp_popped", popped, 8);
        checkOutput("bp_held_max", maxHeld, NSTAGE);
        checkOutput("bp_drain", sb.size(), 0);

        $display("[TB] randomized traffic");
        issued = 0;
        for (int i = 0; i < 600 && (issued < 60 || sb.size() > 0); i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus((issued < 60) && ($urandom_range(0, 3) != 0), $urandom,
                          5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 31)));
            if (accepted) issued++;
        end
        checkOutput("rand_issued", issued, 60);
        out_ready = 1'b1;
        waitDrain(20);

        $display("[TB] reset with operations in flight");
        applyStimulus(1'b1, 32'hAAAA_5555, 5'd1, 2'b00, 5'd21);
        applyStimulus(1'b1, 32'h1357_9BDF, 5'd7, 2'b01, 5'd22);
        applyStimulus(1'b1, 32'hF000_000F, 5'd2, 2'b10, 5'd23);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        checkOutput("flush_valid", out_valid, 1'b0);
        runSingle("post_reset", 32'h0000_00FF, 5'd8, 2'b00, 32'h0000_FF00);
        for (int i = 0; i < NSTAGE; i++) begin
            step();
            checkOutput("post_reset_idle", out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
